// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
//
// Shared definitions for the write-back end of the execute datapath.
//   - Width constants: DATAWIDTH, REGWIDTH, PRSWIDTH, NUM_REGS
//   - PSR bit indices: psrC, psrL, psrF, psrZ, psrN
//   - Condition codes COND_EQ .. COND_NV (4-bit)
//   - cond_eval_f(): evaluates a condition code against a PSR value.
//     Branch control calls the same function, so Scond and conditional
//     branches always decode conditions identically.
//
// No configuration macros are used in this file.
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

   localparam int DATAWIDTH = 16;
   localparam int REGWIDTH  = 4;
   localparam int PRSWIDTH  = 5;
   localparam int NUM_REGS  = 1 << REGWIDTH;

   // Bit positions of the flags inside the PSR.
   localparam int psrC = 0;   // carry
   localparam int psrL = 1;   // low (unsigned compare)
   localparam int psrF = 2;   // flag (overflow)
   localparam int psrZ = 3;   // zero / equal
   localparam int psrN = 4;   // negative (signed compare)

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_HI = 4'd4,
      COND_LS = 4'd5,
      COND_GT = 4'd6,
      COND_LE = 4'd7,
      COND_FS = 4'd8,
      COND_FC = 4'd9,
      COND_LO = 4'd10,
      COND_HS = 4'd11,
      COND_LT = 4'd12,
      COND_GE = 4'd13,
      COND_UC = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   // Pure combinational decode of a condition code. Every one of the 16
   // encodings is listed, so the result is never undefined.
   function automatic logic cond_eval_f(input logic [PRSWIDTH-1:0] p,
                                        input logic [3:0]          c);
      logic z;
      logic l;
      logic n;
      logic f;
      logic cy;
      logic r;
      z  = p[psrZ];
      l  = p[psrL];
      n  = p[psrN];
      f  = p[psrF];
      cy = p[psrC];
      r  = 1'b0;
      case (cond_e'(c))
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = cy;
         COND_CC: r = ~cy;
         COND_HI: r = l;
         COND_LS: r = ~l;
         COND_GT: r = n;
         COND_LE: r = ~n;
         COND_FS: r = f;
         COND_FC: r = ~f;
         COND_LO: r = ~l & ~z;
         COND_HS: r = l | z;
         COND_LT: r = ~n & ~z;
         COND_GE: r = n | z;
         COND_UC: r = 1'b1;
         COND_NV: r = 1'b0;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage : regfile_wb_pkg

// File: rtl/regfile_wb_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
//
// Combinational condition evaluator shared by Scond and branch control.
//
// Ports:
//   psr_i     in  PRSWIDTH  program status register value
//   cond_i    in  4         condition code (COND_EQ .. COND_NV)
//   result_o  out 1         1 when the condition holds for psr_i
//
// No configuration macros are used in this file.
// -----------------------------------------------------------------------------
module cond_eval
   import regfile_wb_pkg::*;
(
   input  logic [PRSWIDTH-1:0] psr_i,
   input  logic [3:0]          cond_i,
   output logic                result_o
);

   always_comb begin
      result_o = cond_eval_f(psr_i, cond_i);
   end

endmodule : cond_eval

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
//
// Write-back end of the execute datapath: a 16 x 16-bit register file with a
// one-entry write-back staging register, two combinational read ports, the
// program status register, and the condition evaluator driving COND_RSLT.
//
// Ports:
//   clk        in  1          single clock, all state on the rising edge
//   reset      in  1          synchronous, active-high
//   write      in  1          write-back enable for this cycle
//   rWb        in  REGWIDTH   write-back destination register
//   wb_data    in  DATAWIDTH  write-back data
//   rSrc       in  REGWIDTH   source read address
//   rDst       in  REGWIDTH   destination read address
//   dSrc       out DATAWIDTH  source read data (combinational)
//   dDst       out DATAWIDTH  destination read data (combinational)
//   psr_we     in  1          capture psrIn into the PSR
//   psrIn      in  PRSWIDTH   flags from the ALU
//   psr        out PRSWIDTH   registered PSR
//   cond       in  4          condition code
//   COND_RSLT  out 1          cond evaluated against the registered PSR
//
// Configuration macro:
//   WB_BYPASS_EN  defined   : read ports forward the staged write (RAW = 1)
//                 undefined : read ports return the array only   (RAW = 2)
//
// Pipeline: a write presented in cycle N is staged at edge N+1 and committed
// to the array at edge N+2. The read ports only ever see registered values,
// so there is no same-cycle path from wb_data back to dSrc/dDst.
// -----------------------------------------------------------------------------
module regfile_wb
   import regfile_wb_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic [REGWIDTH-1:0]  rWb,
   input  logic [DATAWIDTH-1:0] wb_data,
   input  logic [REGWIDTH-1:0]  rSrc,
   input  logic [REGWIDTH-1:0]  rDst,
   output logic [DATAWIDTH-1:0] dSrc,
   output logic [DATAWIDTH-1:0] dDst,
   input  logic                 psr_we,
   input  logic [PRSWIDTH-1:0]  psrIn,
   output logic [PRSWIDTH-1:0]  psr,
   input  logic [3:0]           cond,
   output logic                 COND_RSLT
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                 wb_v_q, wb_v_d;
   logic [REGWIDTH-1:0]  wb_a_q, wb_a_d;
   logic [DATAWIDTH-1:0] wb_d_q, wb_d_d;
   logic [PRSWIDTH-1:0]  psr_q,  psr_d;
   logic [DATAWIDTH-1:0] array_q [NUM_REGS];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every always_comb output gets a value before any branch, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      // The staging register reloads every cycle; wb_v simply follows write,
      // so an idle cycle drops the valid bit without extra control.
      wb_v_d = write;
      wb_a_d = rWb;
      wb_d_d = wb_data;
      psr_d  = psr_q;
      if (psr_we) begin
         psr_d = psrIn;
      end
   end

   // ---------------------------------------------------------------------
   // Staging register and PSR
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the same-edge commit + restage relies on it.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_v_q <= 1'b0;
         wb_a_q <= '0;
         wb_d_q <= '0;
         psr_q  <= '0;
      end else begin
         wb_v_q <= wb_v_d;
         wb_a_q <= wb_a_d;
         wb_d_q <= wb_d_d;
         psr_q  <= psr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Register array
   // ---------------------------------------------------------------------
   // NOTE: the array is architecturally visible as zero after reset, so it
   // is reset explicitly (flops, not a RAM macro). Reset also takes priority
   // over a pending commit, which is how a staged write gets discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            array_q[i] <= '0;
         end
      end else if (wb_v_q) begin
         // Commits leave in staging order, so back-to-back writes to the
         // same register resolve with the later one winning.
         array_q[wb_a_q] <= wb_d_q;
      end
   end

   // ---------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------
   always_comb begin
      dSrc = array_q[rSrc];
      dDst = array_q[rDst];
`ifdef WB_BYPASS_EN
      // Forward the staged (not yet committed) write. Uses only registered
      // values, so no combinational path from wb_data exists.
      if (wb_v_q && (wb_a_q == rSrc)) begin
         dSrc = wb_d_q;
      end
      if (wb_v_q && (wb_a_q == rDst)) begin
         dDst = wb_d_q;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // PSR output and condition evaluation
   // ---------------------------------------------------------------------
   assign psr = psr_q;

   // Evaluated against the registered PSR only: a psr_we in the same cycle
   // has no effect until the following cycle.
   cond_eval u_cond_eval (
      .psr_i    (psr_q),
      .cond_i   (cond),
      .result_o (COND_RSLT)
   );

endmodule : regfile_wb
